residual_adder_multi: RTL and testbench



---
 rtl/residual_adder_multi.sv | 162 ++++++++++++++++
 tb/tb_residual_adder_multi.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/residual_adder_multi.sv
// Multi-lane residual adder: out = sat(round((a*scale_a + b*scale_b) >>> shift)) per lane,
// three-stage pipeline with valid/ready backpressure and per-lane sticky overflow flags.
module residual_adder_multi #(
    parameter int LANES       = 8,
    parameter int IDATA_WIDTH = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_vld,
    input  logic [SCALE_WIDTH-1:0]       scale_a,
    input  logic [SCALE_WIDTH-1:0]       scale_b,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    input  logic                         round_en,
    input  logic [LANES*IDATA_WIDTH-1:0] in_data_a,
    input  logic [LANES*IDATA_WIDTH-1:0] in_data_b,
    input  logic                         in_data_vld,
    output logic                         in_data_rdy,
    output logic [LANES*IDATA_WIDTH-1:0] out_data,
    output logic                         out_data_vld,
    input  logic                         out_data_rdy,
    output logic [LANES-1:0]             ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int PROD_W = IDATA_WIDTH + SCALE_WIDTH + 1;
    localparam int SUM_W  = IDATA_WIDTH + SCALE_WIDTH + 3;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-IDATA_WIDTH+1){1'b0}}, {(IDATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [SUM_W-1:0] f_round_bias(
        input logic [SHIFT_WIDTH-1:0] sh,
        input logic                   en
    );
        f_round_bias = '0;
        if (en && (sh != '0) && (int'(sh) < SUM_W))
            f_round_bias = SUM_W'(1) << (sh - 1'b1);
    endfunction

    function automatic logic signed [SUM_W-1:0] f_shift(
        input logic signed [SUM_W-1:0] v,
        input logic [SHIFT_WIDTH-1:0]  sh
    );
        // Shifts past the sum width collapse to the sign: 0 or -1.
        if (int'(sh) >= SUM_W)
            f_shift = {SUM_W{v[SUM_W-1]}};
        else
            f_shift = v >>> sh;
    endfunction

    // Returns {overflow, saturated value}.
    function automatic logic [IDATA_WIDTH:0] f_sat(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX)
            f_sat = {1'b1, SAT_MAX[IDATA_WIDTH-1:0]};
        else if (v < SAT_MIN)
            f_sat = {1'b1, SAT_MIN[IDATA_WIDTH-1:0]};
        else
            f_sat = {1'b0, v[IDATA_WIDTH-1:0]};
    endfunction

    logic [SCALE_WIDTH-1:0]    r_scale_a;
    logic [SCALE_WIDTH-1:0]    r_scale_b;
    logic [SHIFT_WIDTH-1:0]    r_shift;
    logic                      r_round_en;

    logic                      r_vld_p1;
    logic                      r_vld_p2;
    logic signed [PROD_W-1:0]  r_pa_p1 [LANES];
    logic signed [PROD_W-1:0]  r_pb_p1 [LANES];
    logic [SHIFT_WIDTH-1:0]    r_shift_p1;
    logic                      r_rnd_p1;
    logic signed [SUM_W-1:0]   r_sum_p2 [LANES];
    logic [SHIFT_WIDTH-1:0]    r_shift_p2;

    logic                      w_advance;
    logic signed [PROD_W-1:0]  w_pa [LANES];
    logic signed [PROD_W-1:0]  w_pb [LANES];
    logic signed [SUM_W-1:0]   w_bias;
    logic signed [SUM_W-1:0]   w_sum [LANES];
    logic [IDATA_WIDTH:0]      w_sat [LANES];
    logic [LANES*IDATA_WIDTH-1:0] w_out;
    logic [LANES-1:0]          w_ovf_set;

    // The whole pipeline moves as one; a full output register blocks everything.
    assign w_advance   = ~out_data_vld | out_data_rdy;
    assign in_data_rdy = w_advance;

    // Stage 1: products against the registered (old) configuration
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_pa[i] = PROD_W'($signed(in_data_a[i*IDATA_WIDTH +: IDATA_WIDTH]))
                    * PROD_W'($signed({1'b0, r_scale_a}));
            w_pb[i] = PROD_W'($signed(in_data_b[i*IDATA_WIDTH +: IDATA_WIDTH]))
                    * PROD_W'($signed({1'b0, r_scale_b}));
        end
    end

    // Stage 2: widened sum plus rounding bias
    assign w_bias = f_round_bias(r_shift_p1, r_rnd_p1);

    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_sum[i] = SUM_W'(r_pa_p1[i]) + SUM_W'(r_pb_p1[i]) + w_bias;
    end

    // Stage 3: shift, saturate, flag overflow for beats entering the output register
    always_comb begin
        w_out     = '0;
        w_ovf_set = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sat[i] = f_sat(f_shift(r_sum_p2[i], r_shift_p2));
            w_out[i*IDATA_WIDTH +: IDATA_WIDTH] = w_sat[i][IDATA_WIDTH-1:0];
            w_ovf_set[i] = w_sat[i][IDATA_WIDTH] & r_vld_p2 & w_advance;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int i = 0; i < LANES; i++) begin
                r_pa_p1[i]  <= w_pa[i];
                r_pb_p1[i]  <= w_pb[i];
                r_sum_p2[i] <= w_sum[i];
            end
            r_shift_p1 <= r_shift;
            r_rnd_p1   <= r_round_en;
            r_shift_p2 <= r_shift_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scale_a    <= '0;
            r_scale_b    <= '0;
            r_shift      <= '0;
            r_round_en   <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            out_data_vld <= 1'b0;
            out_data     <= '0;
            ovf_sticky   <= '0;
        end else begin
            if (cfg_vld) begin
                r_scale_a  <= scale_a;
                r_scale_b  <= scale_b;
                r_shift    <= shift;
                r_round_en <= round_en;
            end
            if (w_advance) begin
                r_vld_p1     <= in_data_vld;
                r_vld_p2     <= r_vld_p1;
                out_data_vld <= r_vld_p2;
                if (r_vld_p2)
                    out_data <= w_out;
            end
            // A new overflow wins over a simultaneous clear.
            ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | w_ovf_set;
        end
    end

endmodule

// File: tb/tb_residual_adder_multi.sv
// Bench for residual_adder_multi: table vectors, randomised lane streams under
// backpressure, and hand sequences for config, overflow, stall and reset corners.
module tb_residual_adder_multi;

    localparam int L     = 8;
    localparam int W     = 8;
    localparam int SUM_W = 19;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_vld = 1'b0;
    logic [7:0]     scale_a = '0;
    logic [7:0]     scale_b = '0;
    logic [4:0]     shift = '0;
    logic           round_en = 1'b0;
    logic [L*W-1:0] in_data_a = '0;
    logic [L*W-1:0] in_data_b = '0;
    logic           in_data_vld = 1'b0;
    logic           in_data_rdy;
    logic [L*W-1:0] out_data;
    logic           out_data_vld;
    logic           out_data_rdy = 1'b0;
    logic [L-1:0]   ovf_sticky;
    logic           ovf_clr = 1'b0;

    residual_adder_multi #(.LANES(L), .IDATA_WIDTH(W), .SCALE_WIDTH(8), .SHIFT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .scale_a(scale_a), .scale_b(scale_b),
        .shift(shift), .round_en(round_en), .in_data_a(in_data_a), .in_data_b(in_data_b),
        .in_data_vld(in_data_vld), .in_data_rdy(in_data_rdy), .out_data(out_data),
        .out_data_vld(out_data_vld), .out_data_rdy(out_data_rdy), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             n_rx    = 0;
    logic [L*W-1:0] sb_q[$];
    logic           hold_prev = 1'b0;
    logic [L*W-1:0] data_prev = '0;
    logic           rnd_done = 1'b0;

    typedef struct {
        int sa; int sb; int sh; bit rnd; int a; int b; int exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model(input int a, input int b, input int sa, input int sb,
                                         input int sh, input bit rnd);
        longint p, r;
        p = longint'(a * sa + b * sb);
        if (sh >= SUM_W) begin
            r = (p < 0) ? -1 : 0;
        end else begin
            if (rnd && sh > 0) p = p + (longint'(1) << (sh - 1));
            r = p >>> sh;
        end
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    // Output monitor / scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_vld", 64'(out_data_vld), 64'd1);
                    check("hold_data", out_data, data_prev);
                end
                if (out_data_vld && out_data_rdy) begin
                    n_rx++;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h, required no beat", out_data);
                    end else begin
                        check("beat", out_data, sb_q.pop_front());
                    end
                end
                hold_prev = out_data_vld && !out_data_rdy;
                data_prev = out_data;
            end
        end
    end

    task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [L*W-1:0] e);
        int n;
        n = 0;
        in_data_a = a;
        in_data_b = b;
        in_data_vld = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_data_rdy && n < 200);
        if (!in_data_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_data_rdy 0 after %0d cycles, required 1", n);
        end else begin
            sb_q.push_back(e);
        end
        tick();
        in_data_vld = 1'b0;
    endtask

    task automatic send_rand(input int sa, input int sb, input int sh, input bit rnd);
        logic [L*W-1:0] a, b, e;
        int av, bv;
        for (int i = 0; i < L; i++) begin
            av = int'($urandom_range(0, 255)) - 128;
            bv = int'($urandom_range(0, 255)) - 128;
            a[i*W +: W] = 8'(av);
            b[i*W +: W] = 8'(bv);
            e[i*W +: W] = model(av, bv, sa, sb, sh, rnd);
        end
        send(a, b, e);
    endtask

    task automatic cfg(input int sa, input int sb, input int sh, input bit rnd);
        scale_a  = 8'(sa);
        scale_b  = 8'(sb);
        shift    = 5'(sh);
        round_en = rnd;
        cfg_vld  = 1'b1;
        tick();
        cfg_vld  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(sb_q.size()), 64'd0);
        tick();
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rx0, bad, sa, sb, sh;
        logic [L*W-1:0] s1a, s1e, s2a, s2e;

        tbl.push_back('{8, 8, 3, 0,  1,   1,   2});
        tbl.push_back('{8, 8, 3, 0,  2,   4,   6});
        tbl.push_back('{8, 8, 3, 0,  4,  25,  29});
        tbl.push_back('{8, 8, 3, 0, -4,  25,  21});
        tbl.push_back('{8, 8, 3, 0, -4, -25, -29});
        tbl.push_back('{8, 8, 3, 1,  1,   1,   2});
        tbl.push_back('{8, 8, 3, 1,  3,   2,   5});
        tbl.push_back('{8, 8, 3, 1, -4, -25, -29});
        tbl.push_back('{8, 8, 3, 1,  1,   0,   1});
        tbl.push_back('{1, 8, 1, 1,  1,   0,   1});
        tbl.push_back('{1, 8, 1, 1, -1,   0,   0});
        tbl.push_back('{8, 8, 0, 1,  3,   2,  40});
        tbl.push_back('{8, 8, 4, 0, -1,   0,  -1});
        tbl.push_back('{8, 8, 4, 1, -1,   0,   0});
        tbl.push_back('{255, 0, 8, 1, -128, 0, -127});
        tbl.push_back('{255, 0, 8, 1,  127, 0,  127});
        tbl.push_back('{8, 8, 31, 0, -1,  0,  -1});
        tbl.push_back('{8, 8, 31, 0,  1,  0,   0});
        tbl.push_back('{8, 8, 0, 0,  127,  127,  127});
        tbl.push_back('{8, 8, 0, 0, -128, -128, -128});

        // Reset state
        repeat (3) tick();
        check("rst_out_vld", 64'(out_data_vld), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_ovf", 64'(ovf_sticky), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_in_rdy", 64'(in_data_rdy), 64'd1);
        out_data_rdy = 1'b1;

        // Latency
        cfg(8, 8, 3, 0);
        in_data_a = {L{8'd1}};
        in_data_b = {L{8'd1}};
        in_data_vld = 1'b1;
        sb_q.push_back({L{8'd2}});
        tick();
        in_data_vld = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_data_vld && n < 8);
        check("latency", 64'(n), 64'd3);
        drain();

        // Table vectors, all lanes identical
        foreach (tbl[k]) begin
            cfg(tbl[k].sa, tbl[k].sb, tbl[k].sh, tbl[k].rnd);
            send({L{8'(tbl[k].a)}}, {L{8'(tbl[k].b)}}, {L{8'(tbl[k].exp)}});
        end
        drain();

        // Random lane data under random backpressure
        for (int r = 0; r < 2; r++) begin
            sa = int'($urandom_range(0, 255));
            sb = int'($urandom_range(0, 255));
            sh = int'($urandom_range(0, 12));
            cfg(sa, sb, sh, r[0]);
            rnd_done = 1'b0;
            fork
                begin
                    for (int k = 0; k < 24; k++) send_rand(sa, sb, sh, r[0]);
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        tick();
                        out_data_rdy = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            out_data_rdy = 1'b1;
            drain();
        end

        // Backpressure: six beats against a stalled output
        cfg(8, 8, 0, 0);
        rx0 = n_rx;
        out_data_rdy = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send({L{8'(k)}}, '0, {L{8'(8 * k)}});
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_buffered", 64'(sb_q.size()), 64'd3);
                check("bp_in_rdy", 64'(in_data_rdy), 64'd0);
                check("bp_out_vld", 64'(out_data_vld), 64'd1);
                tick();
                out_data_rdy = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 64'(n_rx - rx0), 64'd6);

        // Config change in the same cycle as beat B
        cfg(8, 8, 3, 0);
        in_data_a = {L{8'd4}};
        in_data_b = {L{8'd25}};
        in_data_vld = 1'b1;
        sb_q.push_back({L{8'd29}});
        tick();
        in_data_a = {L{8'd2}};
        in_data_b = {L{8'd4}};
        shift = 5'd0;
        cfg_vld = 1'b1;
        sb_q.push_back({L{8'd6}});
        tick();
        cfg_vld = 1'b0;
        in_data_a = {L{8'd1}};
        in_data_b = {L{8'd1}};
        sb_q.push_back({L{8'd16}});
        tick();
        in_data_vld = 1'b0;
        drain();

        // Saturation and sticky overflow
        s1a = {{6{8'd1}}, 8'h80, 8'h7f};
        s1e = {{6{8'h10}}, 8'h80, 8'h7f};
        s2a = {{7{8'd1}}, 8'h7f};
        s2e = {{7{8'h10}}, 8'h7f};
        cfg(8, 8, 0, 0);
        pulse_clr();
        check("ovf_cleared0", 64'(ovf_sticky), 64'd0);
        send(s1a, s1a, s1e);
        drain();
        check("ovf_set", 64'(ovf_sticky), 64'h03);
        pulse_clr();
        check("ovf_clr", 64'(ovf_sticky), 64'd0);
        send(s1a, s1a, s1e);
        drain();
        check("ovf_set2", 64'(ovf_sticky), 64'h03);
        in_data_a = s2a;
        in_data_b = s2a;
        in_data_vld = 1'b1;
        sb_q.push_back(s2e);
        tick();
        in_data_vld = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_wins", 64'(ovf_sticky), 64'h01);
        drain();

        // A stalled saturating beat sets the flag only once
        pulse_clr();
        out_data_rdy = 1'b0;
        send(s2a, s2a, s2e);
        repeat (3) tick();
        check("stall_set", 64'(ovf_sticky), 64'h01);
        pulse_clr();
        repeat (2) tick();
        check("stall_no_retrigger", 64'(ovf_sticky), 64'd0);
        out_data_rdy = 1'b1;
        drain();

        // Asynchronous reset with beats in flight
        pulse_clr();
        out_data_rdy = 1'b0;
        in_data_a = s2a;
        in_data_b = s2a;
        in_data_vld = 1'b1;
        repeat (3) tick();
        in_data_vld = 1'b0;
        check("pre_rst_vld", 64'(out_data_vld), 64'd1);
        check("pre_rst_ovf", 64'(ovf_sticky), 64'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vld", 64'(out_data_vld), 64'd0);
        check("async_rst_data", out_data, 64'd0);
        check("async_rst_ovf", 64'(ovf_sticky), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        out_data_rdy = 1'b1;
        check("post_rst_in_rdy", 64'(in_data_rdy), 64'd1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_data_vld) bad++;
        end
        check("no_stale_beat", 64'(bad), 64'd0);
        tick();
        // Config registers came back as zero scales
        send({L{8'd5}}, {L{8'd5}}, '0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
